// File: rtl/dlx_pkg.sv
// Shared DLX definitions: instruction-word defaults, NOP encoding and the
// instruction-memory controller state type.
package dlx_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam logic [31:0] NOP_ENC    = 32'h0000_0000;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } imem_state_t;

endpackage

// File: rtl/dlx_imem_ram.sv
// Simple dual-port word array: one write port and one registered read port
// that returns the pre-write contents on a same-address collision.
module dlx_imem_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dlx_imem.sv
// Loadable DLX instruction memory: post-reset NOP sweep, program-load port
// and a one-cycle registered fetch port with stall hold and range faults.
module dlx_imem
    import dlx_pkg::*;
#(
    parameter int unsigned        DATA_W   = DATA_W_DEF,
    parameter int unsigned        DEPTH    = 64,
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_ENC)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_busy_o,
    output logic              load_err_o,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    input  logic              fetch_stall_i,
    output logic              fetch_valid_o,
    output logic [DATA_W-1:0] fetch_data_o,
    output logic              fetch_fault_o
);

    localparam int unsigned       PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    imem_state_t       state, state_next;
    logic [PTR_W-1:0]  ptr, ptr_next;
    logic              running;
    logic              load_in_range, fetch_in_range;
    logic              hold, accept;
    logic              have_data;
    logic              ram_we, ram_re;
    logic [PTR_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        load_busy_o = 1'b0;
        unique case (state)
            CLEAR: begin
                load_busy_o = 1'b1;
                ptr_next    = ptr + PTR_W'(1);
                if (ptr == PTR_LAST) begin
                    state_next = RUN;
                    ptr_next   = '0;
                end
            end
            RUN: begin
                load_busy_o = 1'b0;
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // Range checks use the full address so high bits can never alias into the array.
    assign running        = (state == RUN);
    assign load_in_range  = ({1'b0, load_addr_i}  < DEPTH_EXT);
    assign fetch_in_range = ({1'b0, fetch_addr_i} < DEPTH_EXT);
    assign hold           = fetch_valid_o & fetch_stall_i;
    assign accept         = running & fetch_req_i & ~hold;

    // The clear sweep borrows the load write port.
    assign ram_we    = load_busy_o | (running & load_en_i & load_in_range);
    assign ram_waddr = load_busy_o ? ptr : load_addr_i[PTR_W-1:0];
    assign ram_wdata = load_busy_o ? NOP_WORD : load_data_i;
    assign ram_re    = accept & fetch_in_range;

    dlx_imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (fetch_addr_i[PTR_W-1:0]),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset; have_data selects NOP until a
    // real in-range word has been read, and after any faulted fetch.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            load_err_o    <= 1'b0;
            fetch_valid_o <= 1'b0;
            fetch_fault_o <= 1'b0;
            have_data     <= 1'b0;
        end else begin
            load_err_o <= running & load_en_i & ~load_in_range;
            if (!hold) begin
                fetch_valid_o <= accept;
                if (accept) begin
                    fetch_fault_o <= ~fetch_in_range;
                    have_data     <= fetch_in_range;
                end
            end
        end
    end

    assign fetch_data_o = have_data ? ram_rdata : NOP_WORD;

endmodule
